// File: rtl/sram_bridge_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bridge_pkg
//  Purpose  : Command codes, FSM state encoding and command decode helpers
//             shared by the AVR-to-SRAM bridge.
//  Revision : 1.0 - initial release
// ============================================================================
package sram_bridge_pkg;

   localparam logic [2:0] CMD_NOP       = 3'd0;
   localparam logic [2:0] CMD_READ      = 3'd1;
   localparam logic [2:0] CMD_WRITE     = 3'd2;
   localparam logic [2:0] CMD_READ_INC  = 3'd3;
   localparam logic [2:0] CMD_WRITE_INC = 3'd4;

   localparam int WAIT_CNT_W = 4;

   typedef enum logic [2:0] {
      ST_IDLE     = 3'd0,
      ST_RD       = 3'd1,
      ST_WR_SETUP = 3'd2,
      ST_WR_PULSE = 3'd3,
      ST_WR_HOLD  = 3'd4
   } state_t;

   function automatic logic cmd_is_read(input logic [2:0] cmd);
      return (cmd == CMD_READ) || (cmd == CMD_READ_INC);
   endfunction

   function automatic logic cmd_is_write(input logic [2:0] cmd);
      return (cmd == CMD_WRITE) || (cmd == CMD_WRITE_INC);
   endfunction

   function automatic logic cmd_is_inc(input logic [2:0] cmd);
      return (cmd == CMD_READ_INC) || (cmd == CMD_WRITE_INC);
   endfunction

   // Codes 5..7 alias NOP, so only the four access codes count as operations
   function automatic logic cmd_is_op(input logic [2:0] cmd);
      return cmd_is_read(cmd) || cmd_is_write(cmd);
   endfunction

endpackage
`default_nettype wire

// File: rtl/sram_addr_sreg.sv
`default_nettype none
// ============================================================================
//  Module   : sram_addr_sreg
//  Purpose  : SRAM address register. Loaded serially MSB first, held, or
//             incremented by one with natural wrap from all-ones to zero.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_addr_sreg #(
   parameter int ADDR_W = 21
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              shift_en,
   input  logic              si,
   input  logic              inc,
   output logic [ADDR_W-1:0] addr
);

   // Increment and shift are never requested together; increment wins anyway
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr <= '0;
      end else if (inc) begin
         addr <= addr + ADDR_W'(1);
      end else if (shift_en) begin
         addr <= {addr[ADDR_W-2:0], si};
      end
   end

endmodule
`default_nettype wire

// File: rtl/sram_bridge.sv
`default_nettype none
// ============================================================================
//  Module   : sram_bridge
//  Purpose  : Bridges a serial-address / parallel-data AVR command port to an
//             asynchronous SRAM with programmable strobe length. All SRAM and
//             AVR-side outputs come straight from flops.
//  Revision : 1.0 - initial release
// ============================================================================
module sram_bridge
   import sram_bridge_pkg::*;
#(
   parameter int ADDR_W   = 21,
   parameter int DATA_W   = 8,
   parameter int WAIT_CYC = 2
) (
   input  logic              avr_clk,
   input  logic              avr_rst_n,
   input  logic              avr_si,
   input  logic              avr_shift_en,
   input  logic [2:0]        avr_cmd,
   input  logic              avr_cmd_valid,
   input  logic [DATA_W-1:0] avr_wdata,
   output logic [DATA_W-1:0] avr_rdata,
   output logic              avr_rdata_valid,
   output logic              avr_busy,
   output logic              avr_cmd_drop,
   output logic [ADDR_W-1:0] sram_addr,
   input  logic [DATA_W-1:0] sram_dq_i,
   output logic [DATA_W-1:0] sram_dq_o,
   output logic              sram_dq_oe,
   output logic              sram_ce_n,
   output logic              sram_oe_n,
   output logic              sram_we_n
);

   localparam logic [WAIT_CNT_W-1:0] WAIT_LOAD = WAIT_CNT_W'(WAIT_CYC);

   state_t                state;
   logic [WAIT_CNT_W-1:0] wait_cnt;
   logic                  inc_flag;

   logic                  accept;
   logic                  addr_shift;
   logic                  addr_inc;

   // Command acceptance and address-register control derived from current state
   always_comb begin
      accept     = (state == ST_IDLE) && avr_cmd_valid && cmd_is_op(avr_cmd);
      // An accepted command uses the pre-shift address, so shifting is suppressed
      addr_shift = (state == ST_IDLE) && avr_shift_en && !accept;
      addr_inc   = inc_flag &&
                   (((state == ST_RD) && (wait_cnt == '0)) || (state == ST_WR_HOLD));
   end

   sram_addr_sreg #(
      .ADDR_W (ADDR_W)
   ) u_addr (
      .clk      (avr_clk),
      .rst_n    (avr_rst_n),
      .shift_en (addr_shift),
      .si       (avr_si),
      .inc      (addr_inc),
      .addr     (sram_addr)
   );

   // Access sequencer: state, wait counter and every registered output
   always_ff @(posedge avr_clk or negedge avr_rst_n) begin
      if (!avr_rst_n) begin
         state           <= ST_IDLE;
         wait_cnt        <= '0;
         inc_flag        <= 1'b0;
         avr_rdata       <= '0;
         avr_rdata_valid <= 1'b0;
         avr_busy        <= 1'b0;
         avr_cmd_drop    <= 1'b0;
         sram_dq_o       <= '0;
         sram_dq_oe      <= 1'b0;
         sram_ce_n       <= 1'b1;
         sram_oe_n       <= 1'b1;
         sram_we_n       <= 1'b1;
      end else begin
         avr_rdata_valid <= 1'b0;
         avr_cmd_drop    <= (state != ST_IDLE) && avr_cmd_valid && cmd_is_op(avr_cmd);

         case (state)
            ST_IDLE: begin
               if (avr_cmd_valid && cmd_is_read(avr_cmd)) begin
                  state     <= ST_RD;
                  wait_cnt  <= WAIT_LOAD;
                  inc_flag  <= cmd_is_inc(avr_cmd);
                  avr_busy  <= 1'b1;
                  sram_ce_n <= 1'b0;
                  sram_oe_n <= 1'b0;
               end else if (avr_cmd_valid && cmd_is_write(avr_cmd)) begin
                  state      <= ST_WR_SETUP;
                  inc_flag   <= cmd_is_inc(avr_cmd);
                  sram_dq_o  <= avr_wdata;
                  avr_busy   <= 1'b1;
                  sram_ce_n  <= 1'b0;
                  sram_dq_oe <= 1'b1;
               end
            end

            ST_RD: begin
               if (wait_cnt == '0) begin
                  state           <= ST_IDLE;
                  avr_rdata       <= sram_dq_i;
                  avr_rdata_valid <= 1'b1;
                  avr_busy        <= 1'b0;
                  sram_ce_n       <= 1'b1;
                  sram_oe_n       <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            ST_WR_SETUP: begin
               state     <= ST_WR_PULSE;
               wait_cnt  <= WAIT_LOAD;
               sram_we_n <= 1'b0;
            end

            ST_WR_PULSE: begin
               if (wait_cnt == '0) begin
                  state     <= ST_WR_HOLD;
                  sram_we_n <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt - 4'd1;
               end
            end

            ST_WR_HOLD: begin
               state      <= ST_IDLE;
               avr_busy   <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
            end

            default: begin
               state      <= ST_IDLE;
               avr_busy   <= 1'b0;
               sram_ce_n  <= 1'b1;
               sram_oe_n  <= 1'b1;
               sram_we_n  <= 1'b1;
               sram_dq_oe <= 1'b0;
            end
         endcase
      end
   end

endmodule
`default_nettype wire

// File: doc/sram_bridge.md
SRAM_BRIDGE -- requirements
Module: sram_bridge

Interface
REQ-001 Parameter ADDR_W, default 21, SRAM address width.
REQ-002 Parameter DATA_W, default 8, SRAM/AVR data width.
REQ-003 Parameter WAIT_CYC, default 2, range 0..15, extra strobe cycles per SRAM access.
REQ-004 avr_clk  input  1  single system clock, all logic on rising edge.
REQ-005 avr_rst_n  input  1  asynchronous, active-low reset.
REQ-006 avr_si  input  1  serial address bit, MSB first.
REQ-007 avr_shift_en  input  1  shift avr_si into address register this cycle.
REQ-008 avr_cmd  input  3  command code: 0 NOP, 1 READ, 2 WRITE, 3 READ_INC, 4 WRITE_INC, 5..7 NOP.
REQ-009 avr_cmd_valid  input  1  one-cycle command strobe.
REQ-010 avr_wdata  input  DATA_W  write data, captured on command accept.
REQ-011 avr_rdata  output  DATA_W  read data, held until next read completes.
REQ-012 avr_rdata_valid  output  1  one-cycle pulse, avr_rdata updated.
REQ-013 avr_busy  output  1  access in progress.
REQ-014 avr_cmd_drop  output  1  one-cycle pulse, command rejected while busy.
REQ-015 sram_addr  output  ADDR_W  current address register.
REQ-016 sram_dq_i  input  DATA_W  SRAM data in.
REQ-017 sram_dq_o  output  DATA_W  SRAM data out.
REQ-018 sram_dq_oe  output  1  drive sram_dq_o onto bus (tristate at top level).
REQ-019 sram_ce_n, sram_oe_n, sram_we_n  output  1 each  active-low SRAM strobes.

Function
REQ-020 States IDLE, RD, WR_SETUP, WR_PULSE, WR_HOLD; all outputs registered.
REQ-021 IDLE: cmd_valid with READ/READ_INC -> RD; WRITE/WRITE_INC -> WR_SETUP; NOP codes -> stay IDLE, no effect.
REQ-022 Accept cycle T latches avr_wdata and inc flag; avr_busy high from T+1 until state returns to IDLE.
REQ-023 RD lasts WAIT_CYC+1 cycles: ce_n=0, oe_n=0, we_n=1, dq_oe=0.
REQ-024 sram_dq_i sampled on last RD edge; avr_rdata and avr_rdata_valid=1 in cycle T+WAIT_CYC+2, state IDLE.
REQ-025 WR_SETUP 1 cycle: ce_n=0, dq_oe=1, we_n=1, oe_n=1.
REQ-026 WR_PULSE WAIT_CYC+1 cycles: ce_n=0, we_n=0, dq_oe=1.
REQ-027 WR_HOLD 1 cycle: ce_n=0, we_n=1, dq_oe=1; then IDLE at T+WAIT_CYC+4.
REQ-028 oe_n and we_n never low simultaneously; dq_oe never high while oe_n low.
REQ-029 Shift: in IDLE with avr_shift_en, addr <= {addr[ADDR_W-2:0], avr_si}.
REQ-030 avr_shift_en ignored while busy and in the cycle a command is accepted (command wins, uses pre-shift address).
REQ-031 _INC commands add 1 to addr on the edge leaving RD/WR_HOLD, modulo 2^ADDR_W (all-ones wraps to 0).
REQ-032 cmd_valid while busy (any non-NOP code): ignored, avr_cmd_drop pulses next cycle, access unaffected.
REQ-033 sram_addr stable for the entire access.

Reset
REQ-034 Asserting avr_rst_n low forces IDLE immediately, mid-access included.
REQ-035 Reset values: addr=0, avr_rdata=0, avr_rdata_valid=0, avr_busy=0, avr_cmd_drop=0, sram_dq_o=0, sram_dq_oe=0, sram_ce_n=1, sram_oe_n=1, sram_we_n=1.
REQ-036 An aborted write yields no rdata_valid and no address increment.

Structure
REQ-037 Package sram_bridge_pkg holds command code constants and the state enum.
REQ-038 Sub-module sram_addr_sreg (ADDR_W) implements shift, hold and wrap increment of the address.
REQ-039 Wait counter width 4 bits; no other sub-modules.

Verification (ADDR_W=21, DATA_W=8, WAIT_CYC=2)
REQ-040 Shift 21 bits of 0x12345 MSB first, READ, sram_dq_i=0xA5 -> sram_addr=0x12345, oe_n low 3 cycles, rdata=0xA5 valid at T+4.
REQ-041 WRITE_INC at addr 0x00010, wdata=0x3C -> we_n low T+2..T+4, dq_o=0x3C with dq_oe T+1..T+5, addr=0x00011 at T+6.
REQ-042 READ_INC at addr 0x1FFFFF -> addr=0x000000 after access.
REQ-043 WRITE then cmd_valid READ at T+2 -> cmd_drop pulse at T+3, write completes unchanged, no read.
REQ-044 avr_rst_n low at T+3 of a write -> we_n=1, ce_n=1, dq_oe=0 immediately, busy=0, addr=0.
REQ-045 cmd_valid READ and avr_shift_en in same IDLE cycle -> read uses old address, address unchanged.
